// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Fetch-side controller and IF/ID pipeline register. Captures the
//             fetched instruction each cycle, decodes the control-flow opcodes
//             (JMP, BRZ, HALT) and returns the PC enable, the PC mux select and
//             the branch target to the fetch stage. It squashes the wrong-path
//             slot after a redirect, honours back-end stalls and keeps a
//             saturating count of squashed slots.
//  Ports    :
//    clk         in   rising-edge clock
//    rst         in   asynchronous active-low reset
//    instr       in   instruction at the current PC (combinational read)
//    zero_in     in   zero flag from execute, condition for BRZ
//    stall_in    in   back-end stall request
//    pc_en       out  PC register enable
//    mux_sel     out  PC mux select: 0 = PC+1, 1 = branch_addr
//    branch_addr out  redirect target
//    id_instr    out  IF/ID instruction register
//    id_valid    out  id_instr holds a valid, non-squashed instruction
//    flush_cnt   out  saturating count of squashed slots
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARQ-1:0]              instr,
    input  logic                        zero_in,
    input  logic                        stall_in,
    output logic                        pc_en,
    output logic                        mux_sel,
    output logic [MEMORY_ADDR_SIZE-1:0] branch_addr,
    output logic [ARQ-1:0]              id_instr,
    output logic                        id_valid,
    output logic [7:0]                  flush_cnt
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_BRZ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ARQ-1:0] id_instr_nxt;
    logic           id_valid_nxt;
    logic [7:0]     flush_cnt_nxt;

    logic [3:0] opcode;
    logic       is_jmp;
    logic       is_brz_taken;
    logic       halt_decode;
    logic       redirect;

    // ------------------------------------------------------------------------
    // Decode of the instruction sitting in the IF/ID register
    // ------------------------------------------------------------------------
    assign opcode       = id_instr[ARQ-1:ARQ-4];
    assign is_jmp       = (opcode == OP_JMP);
    assign is_brz_taken = (opcode == OP_BRZ) && zero_in;
    assign halt_decode  = id_valid && (opcode == OP_HALT);

    // A stalled branch keeps its slot in id_instr, so gating redirect with
    // stall_in is all it takes to defer it to the first free cycle. The
    // squashed FLUSH slot always has id_valid=0, so it is never decoded.
    assign redirect = (state != ST_HALT) && id_valid && !stall_in
                      && (is_jmp || is_brz_taken);

    // ------------------------------------------------------------------------
    // Fetch-stage controls
    // ------------------------------------------------------------------------
    // rst is folded in so pc_en drops the moment reset is asserted, without
    // waiting for the registers to settle.
    assign pc_en       = rst && !stall_in && (state != ST_HALT) && !halt_decode;
    assign mux_sel     = redirect;
    assign branch_addr = redirect ? id_instr[MEMORY_ADDR_SIZE-1:0]
                                  : '0;

    // ------------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        id_instr_nxt  = id_instr;
        id_valid_nxt  = id_valid;
        flush_cnt_nxt = flush_cnt;

        if (!stall_in) begin
            unique case (state)
                ST_RUN: begin
                    id_instr_nxt = instr;
                    if (redirect) begin
                        // The instruction fetched this cycle is wrong-path.
                        id_valid_nxt = 1'b0;
                        state_nxt    = ST_FLUSH;
                        if (flush_cnt != CNT_MAX) begin
                            flush_cnt_nxt = flush_cnt + 8'd1;
                        end
                    end else if (halt_decode) begin
                        id_valid_nxt = 1'b0;
                        state_nxt    = ST_HALT;
                    end else begin
                        id_valid_nxt = 1'b1;
                    end
                end

                ST_FLUSH: begin
                    // The PC was loaded with the target at the end of the
                    // redirect cycle, so this capture is the target.
                    id_instr_nxt = instr;
                    id_valid_nxt = 1'b1;
                    state_nxt    = ST_RUN;
                end

                ST_HALT: begin
                    // Only reset leaves HALT; id_instr stays frozen.
                    id_valid_nxt = 1'b0;
                end

                default: begin
                    state_nxt    = ST_RUN;
                    id_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and pipeline registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            id_instr  <= '0;
            id_valid  <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            id_instr  <= id_instr_nxt;
            id_valid  <= id_valid_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // NOP is architecturally meaningful only to the back end; here it simply
    // flows through like any undecoded opcode.
    logic unused_nop;
    assign unused_nop = (opcode == OP_NOP);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        zero_in;
    logic        stall_in;
    logic        pc_en;
    logic        mux_sel;
    logic [5:0]  branch_addr;
    logic [15:0] id_instr;
    logic        id_valid;
    logic [7:0]  flush_cnt;

    int total;
    int bad;

    fetch_ctrl #(
        .ARQ              (16),
        .MEMORY_ADDR_SIZE (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .zero_in     (zero_in),
        .stall_in    (stall_in),
        .pc_en       (pc_en),
        .mux_sel     (mux_sel),
        .branch_addr (branch_addr),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_cnt;

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        instr    = 16'h1234;
        zero_in  = 1'b0;
        stall_in = 1'b0;

        // ---------------- reset ----------------
        #12;
        check("rst_pc_en",    {15'd0, pc_en},    16'd0);
        check("rst_mux_sel",  {15'd0, mux_sel},  16'd0);
        check("rst_baddr",    {10'd0, branch_addr}, 16'd0);
        check("rst_id_valid", {15'd0, id_valid}, 16'd0);
        check("rst_id_instr", id_instr,          16'h0000);
        check("rst_flush",    {8'd0, flush_cnt}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("first_id_instr", id_instr,          16'h1234);
        check("first_id_valid", {15'd0, id_valid}, 16'd1);
        check("first_pc_en",    {15'd0, pc_en},    16'd1);

        // ---------------- JMP ----------------
        instr = 16'hE02A;
        tick();
        instr = 16'h1111;                 // wrong-path fetch
        #1;
        check("jmp_mux_sel", {15'd0, mux_sel},    16'd1);
        check("jmp_baddr",   {10'd0, branch_addr}, 16'h002A);
        check("jmp_pc_en",   {15'd0, pc_en},      16'd1);
        tick();
        check("jmp_bubble",  {15'd0, id_valid},   16'd0);
        check("jmp_flush",   {8'd0, flush_cnt},   16'd1);
        check("jmp_mux_off", {15'd0, mux_sel},    16'd0);
        instr = 16'h2222;                 // target
        tick();
        check("jmp_tgt_valid", {15'd0, id_valid}, 16'd1);
        check("jmp_tgt_instr", id_instr,          16'h2222);

        // ---------------- BRZ not taken ----------------
        instr = 16'hD011;
        tick();
        zero_in = 1'b0;
        instr   = 16'h3333;
        #1;
        check("brz0_mux_sel", {15'd0, mux_sel},     16'd0);
        check("brz0_baddr",   {10'd0, branch_addr}, 16'd0);
        tick();
        check("brz0_valid",   {15'd0, id_valid},    16'd1);
        check("brz0_instr",   id_instr,             16'h3333);
        check("brz0_flush",   {8'd0, flush_cnt},    16'd1);

        // ---------------- BRZ taken ----------------
        instr = 16'hD011;
        tick();
        zero_in = 1'b1;
        instr   = 16'h4444;
        #1;
        check("brz1_mux_sel", {15'd0, mux_sel},     16'd1);
        check("brz1_baddr",   {10'd0, branch_addr}, 16'h0011);
        tick();
        zero_in = 1'b0;
        check("brz1_bubble",  {15'd0, id_valid},    16'd0);
        check("brz1_flush",   {8'd0, flush_cnt},    16'd2);
        instr = 16'h5555;
        tick();
        check("brz1_tgt",     id_instr,             16'h5555);
        check("brz1_valid",   {15'd0, id_valid},    16'd1);

        // ---------------- stall with pending JMP ----------------
        instr = 16'hE005;
        tick();
        stall_in = 1'b1;
        instr    = 16'h6666;
        #1;
        check("stl_pc_en",   {15'd0, pc_en},       16'd0);
        check("stl_mux_sel", {15'd0, mux_sel},     16'd0);
        check("stl_baddr",   {10'd0, branch_addr}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_hold_instr", id_instr,          16'hE005);
            check("stl_hold_valid", {15'd0, id_valid}, 16'd1);
            check("stl_hold_pc_en", {15'd0, pc_en},    16'd0);
        end
        stall_in = 1'b0;
        #1;
        check("stl_rel_mux",   {15'd0, mux_sel},     16'd1);
        check("stl_rel_baddr", {10'd0, branch_addr}, 16'h0005);
        check("stl_rel_pc_en", {15'd0, pc_en},       16'd1);
        tick();
        check("stl_bubble",    {15'd0, id_valid},    16'd0);
        check("stl_flush",     {8'd0, flush_cnt},    16'd3);
        instr = 16'h7777;
        tick();
        check("stl_tgt",       id_instr,             16'h7777);

        // ---------------- back-to-back branches ----------------
        instr = 16'hE010;
        tick();
        instr = 16'hE020;                 // wrong-path branch
        #1;
        check("b2b_mux",    {15'd0, mux_sel},     16'd1);
        check("b2b_baddr",  {10'd0, branch_addr}, 16'h0010);
        tick();
        check("b2b_sq_instr", id_instr,           16'hE020);
        check("b2b_sq_valid", {15'd0, id_valid},  16'd0);
        check("b2b_sq_mux",   {15'd0, mux_sel},   16'd0);
        instr = 16'h0000;
        tick();
        check("b2b_tgt_valid", {15'd0, id_valid}, 16'd1);
        check("b2b_no_redir",  {15'd0, mux_sel},  16'd0);
        check("b2b_flush",     {8'd0, flush_cnt}, 16'd4);

        // ---------------- HALT ----------------
        instr = 16'hF000;
        tick();
        #1;
        check("halt_pc_en_now", {15'd0, pc_en},   16'd0);
        check("halt_mux",       {15'd0, mux_sel}, 16'd0);
        tick();
        check("halt_valid",     {15'd0, id_valid}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            instr = 16'hE000 + 16'(i);
            tick();
            check("halt_pc_en",  {15'd0, pc_en},    16'd0);
            check("halt_valid",  {15'd0, id_valid}, 16'd0);
            check("halt_instr",  id_instr,          16'hF000);
            check("halt_mux",    {15'd0, mux_sel},  16'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("halt_rst_instr", id_instr,          16'h0000);
        check("halt_rst_flush", {8'd0, flush_cnt}, 16'd0);
        check("halt_rst_pc_en", {15'd0, pc_en},    16'd0);
        rst = 1'b1;
        #1;
        check("halt_exit_pc_en", {15'd0, pc_en},   16'd1);

        // ---------------- flush counter saturation ----------------
        instr   = 16'hE03F;
        exp_cnt = 8'd0;
        tick();                           // JMP captured
        for (int i = 0; i < 260; i++) begin
            tick();                       // redirect edge, now in FLUSH
            exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
            check("sat_cnt", {8'd0, flush_cnt}, {8'd0, exp_cnt});
            tick();                       // FLUSH captures next JMP
        end
        check("sat_final", {8'd0, flush_cnt}, 16'h00FF);

        // ---------------- reset mid-FLUSH ----------------
        tick();                           // enter FLUSH
        check("mf_in_flush", {15'd0, id_valid}, 16'd0);
        rst = 1'b0;
        #1;
        check("mf_rst_flush", {8'd0, flush_cnt}, 16'd0);
        check("mf_rst_instr", id_instr,          16'h0000);
        @(negedge clk);
        rst   = 1'b1;
        instr = 16'h0ABC;
        tick();
        check("mf_run_instr", id_instr,          16'h0ABC);
        check("mf_run_valid", {15'd0, id_valid}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
